// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its result drain.
package systolic_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_M          = 3;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Valid/ready word stream carrying one result element plus its row/col position.
interface systolic_result_drain_if #(
  parameter int unsigned DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH,
  parameter int unsigned M          = systolic_pkg::DEF_M,
  parameter int unsigned IDX_W      = $clog2(M)
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [IDX_W-1:0]      m_row;
  logic [IDX_W-1:0]      m_col;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row,
    output m_col,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row,
    input  m_col,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/systolic_drain_counter.sv
// Row-major row/col counter; wrap flags the final element [M-1][M-1].
module systolic_drain_counter #(
  parameter int unsigned M     = systolic_pkg::DEF_M,
  parameter int unsigned IDX_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(M - 1);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == MaxIdx) begin
        col_d = '0;
        row_d = (row_q == MaxIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign wrap = (row_q == MaxIdx) && (col_q == MaxIdx);

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the M x M result matrix on done and streams it row-major over valid/ready.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned M          = DEF_M,
  parameter int unsigned IDX_W      = $clog2(M)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] result_out [0:M-1][0:M-1],
  input  logic                  done,
  input  logic                  ovr_clear,
  systolic_result_drain_if.master m,
  output logic                  busy,
  output logic                  overrun
);

  drain_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] snapshot_q [0:M-1][0:M-1];
  logic [IDX_W-1:0]      row;
  logic [IDX_W-1:0]      col;
  logic                  wrap;
  logic                  fire;
  logic                  capture;
  logic                  cnt_clr;
  logic                  ovr_set;
  logic                  overrun_q;

  assign fire = (state_q == STREAM) && m.m_ready;

  systolic_drain_counter #(
    .M     (M),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (fire),
    .row   (row),
    .col   (col),
    .wrap  (wrap)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    cnt_clr = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done) begin
          capture = 1'b1;
          cnt_clr = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire && wrap) begin
          // A done coinciding with the final handshake is accepted without a bubble.
          if (done) begin
            capture = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (done) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      overrun_q <= 1'b0;
      for (int r = 0; r < int'(M); r++) begin
        for (int c = 0; c < int'(M); c++) begin
          snapshot_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (ovr_clear) begin
        overrun_q <= 1'b0;
      end
      if (capture) begin
        snapshot_q <= result_out;
      end
    end
  end

  assign m.m_valid = (state_q == STREAM);
  assign m.m_data  = snapshot_q[row][col];
  assign m.m_row   = row;
  assign m.m_col   = col;
  assign m.m_last  = wrap;
  assign busy      = (state_q == STREAM);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain with a 3x3 matrix of 32-bit words.
module tb_systolic_result_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned MM = 3;

  logic          clk;
  logic          reset;
  logic [DW-1:0] result_out [0:MM-1][0:MM-1];
  logic          done;
  logic          ovr_clear;
  logic          busy;
  logic          overrun;

  int passed;
  int total;

  // [[1,2,3],[4,5,6],[7,8,9]] squared, row-major
  int unsigned prod [0:8];

  systolic_result_drain_if #(.DATA_WIDTH(DW), .M(MM)) bus ();

  systolic_result_drain #(
    .DATA_WIDTH (DW),
    .M          (MM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .result_out (result_out),
    .done       (done),
    .ovr_clear  (ovr_clear),
    .m          (bus.master),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic load_product();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        result_out[r][c] = prod[r*3+c];
  endtask

  task automatic load_const(input int unsigned v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        result_out[r][c] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.m_valid), 0);
    check({tag, "_data"}, bus.m_data, 0);
    check({tag, "_row"}, 32'(bus.m_row), 0);
    check({tag, "_col"}, 32'(bus.m_col), 0);
    check({tag, "_last"}, 32'(bus.m_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    prod = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    passed      = 0;
    total       = 0;
    reset       = 1'b1;
    done        = 1'b0;
    ovr_clear   = 1'b0;
    bus.m_ready = 1'b0;
    load_const(0);
    step();
    step();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Single matrix, ready held high
    load_product();
    done = 1'b1;
    step();
    done = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check("single_valid", 32'(bus.m_valid), 1);
      check("single_data", bus.m_data, prod[k]);
      check("single_row", 32'(bus.m_row), k / 3);
      check("single_col", 32'(bus.m_col), k % 3);
      check("single_last", 32'(bus.m_last), 32'(k == 8));
      step();
    end
    check("single_busy_end", 32'(busy), 0);
    check("single_valid_end", 32'(bus.m_valid), 0);

    // Backpressure: ready alternates 0/1, data must hold through each stall
    bus.m_ready = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.m_ready = 1'b0;
      check("bp_data", bus.m_data, prod[k]);
      step();
      check("bp_stall_valid", 32'(bus.m_valid), 1);
      check("bp_stall_data", bus.m_data, prod[k]);
      check("bp_stall_last", 32'(bus.m_last), 32'(k == 8));
      bus.m_ready = 1'b1;
      step();
    end
    check("bp_busy_end", 32'(busy), 0);

    // Back-to-back: second done on the last handshake
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("b2b_first_data", bus.m_data, prod[k]);
      if (k == 8) begin
        load_const(7);
        done = 1'b1;
      end
      step();
      done = 1'b0;
    end
    for (int k = 0; k < 9; k++) begin
      check("b2b_second_valid", 32'(bus.m_valid), 1);
      check("b2b_second_data", bus.m_data, 7);
      check("b2b_second_row", 32'(bus.m_row), k / 3);
      check("b2b_second_col", 32'(bus.m_col), k % 3);
      step();
    end
    check("b2b_busy_end", 32'(busy), 0);
    check("b2b_overrun", 32'(overrun), 0);

    // Overrun: done during beat 3 is dropped
    load_product();
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("ovr_data", bus.m_data, prod[k]);
      if (k == 2) begin
        load_const(5);
        done = 1'b1;
      end
      step();
      done = 1'b0;
      if (k == 2) check("ovr_set", 32'(overrun), 1);
    end
    check("ovr_busy_end", 32'(busy), 0);
    check("ovr_sticky", 32'(overrun), 1);
    ovr_clear = 1'b1;
    step();
    ovr_clear = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);

    // Reset mid-stream after 4 beats, then a clean restart
    load_product();
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("mid_data_before_rst", bus.m_data, prod[4]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("midrst");
    load_const(7);
    done = 1'b1;
    step();
    done = 1'b0;
    check("restart_valid", 32'(bus.m_valid), 1);
    check("restart_data", bus.m_data, 7);
    check("restart_row", 32'(bus.m_row), 0);
    check("restart_col", 32'(bus.m_col), 0);
    for (int k = 0; k < 9; k++) step();
    check("restart_busy_end", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side companion of `systolic_array_integration`. It takes a snapshot of the M×M `result_out` matrix on the cycle `done` pulses, then streams the elements one word per beat over a valid/ready master interface in row-major order. This is the same handshake the input FIFOs use on the load side. It buffers one matrix, so the array can start its next computation while the previous result is still draining.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one result element.
- `M`, 3: array dimension. Legal range is M ≥ 2.
- `IDX_W`, `$clog2(M)`: width of the row and column indices. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `result_out`  in  `[DATA_WIDTH-1:0] [0:M-1][0:M-1]`  result matrix from the array. Valid only in the cycle `done` is high.
- `done`  in  1  one-cycle completion pulse from the array.
- `ovr_clear`  in  1  clears the sticky `overrun` flag.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  DATA_WIDTH  current element.
- `m_row`, `m_col`  out  IDX_W  indices of the current element.
- `m_last`  out  1  high on element [M-1][M-1].
- `busy`  out  1  high while a snapshot is held or draining.
- `overrun`  out  1  sticky flag: a `done` pulse was dropped.

## Operation
- FSM with two states:
  - IDLE: `busy`=0 and `m_valid`=0.
  - STREAM: `busy`=1 and `m_valid`=1.
- IDLE → STREAM: on `done`=1, copy all M×M elements into the snapshot buffer and clear row/col to 0.
- STREAM, beat handshake (`m_valid`&&`m_ready`):
  - col increments. When col wraps from M-1 to 0, row increments.
  - On the handshake of [M-1][M-1], the block returns to IDLE.
- Output hold: while `m_valid`=1 and `m_ready`=0, `m_data`, `m_row`, `m_col` and `m_last` stay stable.
- `m_data` = snapshot[row][col]. `m_last` = (row==M-1 && col==M-1).
- Back-to-back: `done` in the same cycle as the last-beat handshake captures the new matrix and stays in STREAM at [0][0]. No bubble.
- Overrun: `done` while in STREAM, other than the last-beat case above:
  - The pulse is dropped and the snapshot is not modified.
  - `overrun` is set the next cycle and holds until `ovr_clear` or `reset`.
  - If `ovr_clear` and a new overrun occur in the same cycle, set wins.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_row`=0, `m_col`=0, `m_last`=0, `busy`=0, `overrun`=0, state=IDLE, snapshot=0.
- `done` sampled at edge N → `m_valid`=1 with element [0][0] from cycle N+1.
- With `m_ready` held at 1: M² consecutive beats, `m_last` in cycle N+M², and `busy`=0 in cycle N+M²+1.
- `reset` asserted mid-stream: all outputs return to reset values at the next edge. The remaining elements are discarded.
- `m_valid` never depends combinationally on `m_ready`. `m_ready` may be asserted or deasserted in any cycle.

## Structure
- Shared package `systolic_pkg` holds:
  - the `drain_state_t` enum (`IDLE`, `STREAM`);
  - the default `DATA_WIDTH` and `M` constants, shared with `systolic_array_integration`.
- One sub-module: `systolic_drain_counter`. It is a row/col wrap counter with `clr`, `en`, `row`, `col` and `wrap` (asserted at [M-1][M-1]).
- The snapshot buffer, output mux and FSM are inline in the top module.

## Test plan
- **Single matrix.** Drive A=B=[[1,2,3],[4,5,6],[7,8,9]] through the array, or force `result_out` to their product, and pulse `done`. Hold `m_ready`=1. Expect:
  - the words 30,36,42,66,81,96,102,126,150 in that order;
  - `m_last` only on 150;
  - `busy` low 10 cycles after the `done` edge.
- **Backpressure.** Toggle `m_ready` 1/0 every cycle. Expect the same 9 words with no loss or duplication, and `m_data` stable in every stall cycle.
- **Back-to-back.** Pulse `done` with a second matrix (all 7s) in the cycle of the 150 handshake. Expect 150 immediately followed by nine 7s, and `overrun`=0.
- **Overrun.** Pulse `done` with all 5s during beat 3. Expect:
  - the stream continues with the original values;
  - `overrun`=1 the next cycle and still 1 after the stream ends;
  - `ovr_clear` returns it to 0.
- **Reset mid-stream.** Assert `reset` after 4 beats. Expect all outputs at reset values the next cycle. A new `done` restarts cleanly from [0][0].
